// File: rtl/vga_paint.sv
// Bar-colour generator: stretches a one-cycle print pulse into a BAR_WIDTH-pixel bar
// and cycles through a fixed RGB444 palette. Define PAINT_BORDER_EN to blank each bar's first and last pixel.
module vga_paint #(
  parameter int BAR_WIDTH = 40,
  parameter int NUM_BARS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        print,
  output logic [11:0] colour,
  output logic        stat
);

  localparam logic [9:0] BAR_LEN  = 10'(BAR_WIDTH);
  localparam logic [2:0] LAST_IDX = 3'(NUM_BARS - 1);

  // Blue (00F) is deliberately absent: it is the background colour.
  function automatic logic [11:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 12'hF00;
      3'd1:    palette = 12'h0F0;
      3'd2:    palette = 12'hFF0;
      3'd3:    palette = 12'hF0F;
      3'd4:    palette = 12'h0FF;
      3'd5:    palette = 12'hFFF;
      3'd6:    palette = 12'hF80;
      default: palette = 12'h888;
    endcase
  endfunction

  logic [9:0]  cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic        stat_next;
  logic [11:0] colour_next;
`ifdef PAINT_BORDER_EN
  logic [11:0] bar_colour, bar_colour_next;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
    cnt_next    = cnt;
    idx_next    = idx;
    stat_next   = 1'b0;
    colour_next = 12'h000;
`ifdef PAINT_BORDER_EN
    bar_colour_next = bar_colour;
`endif
    if (cnt == 10'd0) begin
      if (print) begin
        cnt_next  = BAR_LEN;
        stat_next = 1'b1;
        idx_next  = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
`ifdef PAINT_BORDER_EN
        bar_colour_next = palette(idx);
`else
        colour_next = palette(idx);
`endif
      end
    end else begin
      // cnt==1 is the edge where stat falls; print is ignored for the whole bar.
      cnt_next  = cnt - 10'd1;
      stat_next = (cnt != 10'd1);
`ifdef PAINT_BORDER_EN
      // cnt==2 means the next pixel is the bar's last one, which is blanked.
      if (cnt > 10'd2) colour_next = bar_colour;
`else
      if (cnt != 10'd1) colour_next = colour;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 10'd0;
      idx    <= 3'd0;
      stat   <= 1'b0;
      colour <= 12'h000;
`ifdef PAINT_BORDER_EN
      bar_colour <= 12'h000;
`endif
    end else begin
      cnt    <= cnt_next;
      idx    <= idx_next;
      stat   <= stat_next;
      colour <= colour_next;
`ifdef PAINT_BORDER_EN
      bar_colour <= bar_colour_next;
`endif
    end
  end

endmodule

// File: tb/tb_vga_paint.sv
// Self-checking bench for vga_paint: directed scenarios plus random print/reset traffic,
// compared every cycle against a time-based model of bar start/end.
module tb_vga_paint;

  localparam int BW = 40;
  localparam int NB = 8;
`ifdef PAINT_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        print;
  logic [11:0] colour;
  logic        stat;

  vga_paint #(.BAR_WIDTH(BW), .NUM_BARS(NB)) dut (
    .clk    (clk),
    .reset  (reset),
    .print  (print),
    .colour (colour),
    .stat   (stat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'hFF0, 12'hF0F,
                           12'h0FF, 12'hFFF, 12'hF80, 12'h888};

  // Model: a bar is the edge number it started on plus its palette slot.
  longint edge_n   = 0;
  longint start_e  = 0;
  bit     active   = 1'b0;
  int     started  = 0;
  int     bar_idx  = 0;
  logic        exp_stat;
  logic [11:0] exp_colour;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_edge(input logic p, input logic r);
    longint k;
    edge_n++;
    if (r) begin
      active  = 1'b0;
      started = 0;
    end else if (p && (!active || edge_n > start_e + BW)) begin
      active  = 1'b1;
      start_e = edge_n;
      bar_idx = started % NB;
      started++;
    end
    exp_stat   = 1'b0;
    exp_colour = 12'h000;
    if (!r && active && (edge_n - start_e) < BW) begin
      k = edge_n - start_e + 1;
      exp_stat   = 1'b1;
      exp_colour = (BORDER && (k == 1 || k == BW)) ? 12'h000 : pal[bar_idx];
    end
  endtask

  task automatic step(input logic p, input logic r);
    print = p;
    reset = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
    check("stat", {31'd0, stat}, {31'd0, exp_stat});
    check("colour", {20'd0, colour}, {20'd0, exp_colour});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  logic [11:0] wrap_exp [9] = '{12'hF00, 12'h0F0, 12'hFF0, 12'hF0F, 12'h0FF,
                                12'hFFF, 12'hF80, 12'h888, 12'hF00};

  initial begin
    int width;
    print = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_stat", {31'd0, stat}, 32'd0);
    check("reset_colour", {20'd0, colour}, 32'd0);
    idle(3);

    // Single bar: measure width directly, then the next bar takes the next colour.
    step(1'b1, 1'b0);
    width = 0;
    for (int i = 0; i < 60; i++) begin
      if (stat) width++;
      step(1'b0, 1'b0);
    end
    check("single_width", width, BW);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("second_colour", {20'd0, colour}, 32'h0F0);
    idle(50);

    // Reset mid-bar at cnt=20, then the next bar restarts at palette entry 0.
    step(1'b1, 1'b0);
    idle(20);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("midbar_reset_stat", {31'd0, stat}, 32'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("post_reset_colour", {20'd0, colour}, 32'hF00);
    idle(50);

    // Palette wrap over nine isolated pulses.
    step(1'b0, 1'b1);
    for (int b = 0; b < 9; b++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check("wrap_colour", {20'd0, colour}, {20'd0, wrap_exp[b]});
      idle(48);
    end

    // Retrigger at bar cycle 5 and at the falling edge must be ignored.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    width = 1;
    for (int c = 1; c <= 45; c++) begin
      step((c == 5 || c == BW), 1'b0);
      if (stat) width++;
    end
    check("retrig_width", width, BW);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("retrig_next_colour", {20'd0, colour}, 32'h0F0);
    idle(50);

    // Held print for 100 cycles: 40 high, 1 low, 40 high, 1 low, 18 high.
    step(1'b0, 1'b1);
    width = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b1, 1'b0);
      if (stat) width++;
    end
    check("held_high_cycles", width, 98);
    check("held_third_colour", {20'd0, colour}, 32'hFF0);
    idle(60);

    // Random traffic with occasional resets and varying print density.
    for (int phase = 0; phase < 6; phase++) begin
      int dens = $urandom_range(2, 60);
      for (int c = 0; c < 600; c++)
        step($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_paint.md
Name: vga_paint

Overview:
- Bar-colour generator for the VGA weights display.
- The display controller pulses `print` when the scan reaches the left edge of a weight bar on the current line.
- `vga_paint` stretches that pulse into a bar segment BAR_WIDTH pixels wide and supplies the bar colour.
- While `stat` is high, the controller shows `colour`; otherwise it shows the blue background (12'h00F).

Parameters:
- BAR_WIDTH, 40: pixels (clock cycles) per bar segment; legal range 2..1023.
- NUM_BARS, 8: palette entries and bar-index wrap point; legal range 1..8.

Ports:
- clk, input, 1: pixel clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- print, input, 1: bar-start request, sampled on the rising edge of clk.
- colour, output, 12: RGB444 pixel colour {R[11:8], G[7:4], B[3:0]}; registered.
- stat, output, 1: high while the current pixel belongs to a bar; registered.

Behaviour:
- State:
  - cnt: 10-bit remaining-pixel counter; 0 means idle.
  - idx: 3-bit bar index, range 0..NUM_BARS-1.
- Reset (sampled high on a clk edge): cnt=0, idx=0, stat=0, colour=12'h000. Reset has priority over everything, including an active bar, which is aborted in that cycle.
- Palette, indexed by idx:
  - 0:F00, 1:0F0, 2:FF0, 3:F0F
  - 4:0FF, 5:FFF, 6:F80, 7:888
  - Blue 00F is never used, because it is the background colour.
- Idle (cnt==0) and print==1 at an edge:
  - cnt ← BAR_WIDTH.
  - stat ← 1.
  - colour ← palette[idx].
  - idx ← (idx==NUM_BARS-1) ? 0 : idx+1.
- Active (cnt!=0) at an edge:
  - cnt ← cnt-1.
  - stat ← (cnt!=1).
  - colour holds while stat stays high.
  - When stat falls, colour ← 12'h000.
- Idle and print==0: all state holds; stat=0, colour=000.
- Latency and width:
  - stat rises on the edge after print is sampled.
  - stat stays high for exactly BAR_WIDTH consecutive cycles.
- Retrigger: print==1 while active (including the edge on which stat falls) is ignored. It neither extends the bar nor advances idx.
  - Earliest restart: print sampled on the first edge at which stat is already 0. The minimum gap between bars is therefore 1 cycle of stat=0.
- Multi-cycle print: print held high re-arms a new bar only after each bar plus its 1-cycle gap; idx advances once per bar actually started.
- colour is always 000 whenever stat=0.

Optional Feature:
- Macro PAINT_BORDER_EN.
- When defined:
  - The first and last pixel of every bar (stat-high cycles 1 and BAR_WIDTH) output colour 12'h000.
  - Interior pixels use the palette; stat timing is unchanged.
- When undefined: every stat-high cycle outputs palette[idx]; no border logic is synthesised.

Test Plan:
- Reset: assert reset for 2 cycles mid-bar (cnt=20) → next edge stat=0, colour=000; a following print starts with colour F00 (idx=0).
- Single bar: after reset, one-cycle print → stat high for exactly 40 cycles starting the next edge, colour=F00 throughout, then stat=0/colour=000; the next bar gets 0F0.
- Palette wrap: 9 isolated print pulses spaced 50 cycles apart → colours F00,0F0,FF0,F0F,0FF,FFF,F80,888,F00.
- Retrigger ignored: print pulses at bar cycles 5 and 40 (the falling edge) → stat width stays 40 and the next bar still uses 0F0.
- Held print: print held high for 100 cycles → stat pattern 40 high, 1 low, 40 high, 1 low, 18 high onward; colours F00, 0F0, FF0.
- PAINT_BORDER_EN: a single bar → colour 000 on stat cycles 1 and 40, F00 on cycles 2-39; stat timing identical to the undefined build.
